pulse_train_scheduler: RTL and testbench
========================================

Name: pulse_train_scheduler

Overview:
Sequences the glitch/trigger output path. Once armed, it waits for a rising edge on the qualified trigger input, waits a programmable delay, then emits a train of programmable-width pulses separated by programmable gaps. Sits between the trigger-condition logic and the pulse extender / output stage in the sampleclk domain. Configuration values arrive as static ports from the register block, already synchronised to sampleclk.

Parameters:
CNT_W, 16, width of the delay, width and gap counters and config ports
NUM_W, 8, width of the pulse-count config and the index output

Ports:
sampleclk  input  1  sole clock; all logic on its rising edge
reset  input  1  synchronous, active-high reset
arm  input  1  one-cycle request to arm (IDLE -> ARMED)
abort  input  1  one-cycle request to cancel any activity
trigger_in  input  1  qualified trigger; rising edge starts a sequence
cfg_delay  input  CNT_W  cycles from edge detection to first pulse
cfg_width  input  CNT_W  pulse high time in cycles (0 treated as 1)
cfg_gap  input  CNT_W  low time between pulses (0 treated as 1)
cfg_count  input  NUM_W  number of pulses (0 = none)
cfg_rearm  input  1  1: return to ARMED after DONE; 0: return to IDLE
pulse_out  output  1  registered pulse train
armed  output  1  high while in ARMED
busy  output  1  high in DELAY, PULSE or GAP
done  output  1  one-cycle strobe when a sequence completes
pulse_index  output  NUM_W  number of pulses already started in the current sequence

Behaviour:
- Reset (synchronous, active-high): state IDLE, pulse_out=0, armed=0, busy=0, done=0, pulse_index=0, counter=0, trigger history register=0. Reset overrides every other input.
- All outputs are registered. armed and busy decode the registered state.
- Edge detect: trig_q <= trigger_in every cycle, in every state. An edge is trigger_in=1 && trig_q=0, sampled at edge E0. Only edges seen in ARMED are acted on. A trigger held high while arming does not fire; it must fall and rise again.
- States:
  - IDLE: arm=1 -> ARMED.
  - ARMED: on an edge, latch cfg_delay, cfg_width, cfg_gap and cfg_count into shadow registers. Later cfg changes are ignored until the next edge. Then:
    - count=0 -> DONE.
    - delay=0 -> PULSE.
    - otherwise -> DELAY, with counter=1.
  - DELAY: increment the counter. When counter==delay -> PULSE. Net effect: pulse_out first goes high at E0+delay+1.
  - PULSE: pulse_out=1 for exactly max(width,1) cycles. On entry, pulse_index increments. At the last high cycle:
    - pulse_index==count -> DONE.
    - otherwise -> GAP.
  - GAP: pulse_out=0 for exactly max(gap,1) cycles, then -> PULSE.
  - DONE: lasts one cycle with done=1 and pulse_out=0. Then:
    - cfg_rearm=1 -> ARMED.
    - cfg_rearm=0 -> IDLE.
    - pulse_index clears on the next entry to ARMED.
- abort=1 in any state: next cycle state=IDLE, pulse_out=0, no done strobe, pulse_index holds its value for debug. abort beats arm and trigger in the same cycle.
- arm asserted outside IDLE is ignored. arm and trigger edge in the same cycle while in IDLE: arm only; that edge is not used.
- Counters do not wrap: delay and width of 2^CNT_W-1 are legal maximum values. cfg_count of 2^NUM_W-1 yields that many pulses.
- Total sequence length in cycles = delay + count*max(width,1) + (count-1)*max(gap,1), measured from E0+1 to the last high cycle inclusive.

Test Plan:
- Reset mid-PULSE -> the next cycle has pulse_out=0, state IDLE, and all outputs 0. A trigger edge afterwards, without arm, gives no pulse.
- arm; trigger edge at E0; delay=5, width=3, gap=2, count=3 -> pulse_out high in cycles E0+6..8, E0+11..13 and E0+16..18. done at E0+19. Final pulse_index=3. Returns to IDLE (cfg_rearm=0).
- delay=0, width=0, gap=0, count=2 -> pulse_out high at E0+1 and E0+3, low at E0+2. done at E0+4.
- count=0 -> no pulse and done one cycle after the edge. With cfg_rearm=1, armed=1 the following cycle, and a second edge is accepted.
- Change cfg_width from 3 to 10 during DELAY -> all pulses in that sequence stay 3 cycles wide.
- abort during GAP of pulse 2 of 4 -> pulse_out stays 0, no done, IDLE next cycle, pulse_index=2. A trigger held high through arm does not fire until it toggles.

Source files
------------

// File: rtl/pulse_train_scheduler_if.sv
// ----------------------------------------------------------------------------
// pulse_train_scheduler_if
// Groups the control, configuration and status signals of the pulse train
// scheduler. The clock (sampleclk) and reset stay plain module ports.
//   master : trigger/register-block side. Drives arm, abort, trigger_in and
//            cfg_*, and observes pulse_out and the status outputs.
//   slave  : the scheduler itself.
// ----------------------------------------------------------------------------
interface pulse_train_scheduler_if #(
   parameter int CNT_W = 16,
   parameter int NUM_W = 8
);
   logic             arm;
   logic             abort;
   logic             trigger_in;
   logic [CNT_W-1:0] cfg_delay;
   logic [CNT_W-1:0] cfg_width;
   logic [CNT_W-1:0] cfg_gap;
   logic [NUM_W-1:0] cfg_count;
   logic             cfg_rearm;
   logic             pulse_out;
   logic             armed;
   logic             busy;
   logic             done;
   logic [NUM_W-1:0] pulse_index;

   modport master (
      output arm, abort, trigger_in, cfg_delay, cfg_width, cfg_gap,
             cfg_count, cfg_rearm,
      input  pulse_out, armed, busy, done, pulse_index
   );

   modport slave (
      input  arm, abort, trigger_in, cfg_delay, cfg_width, cfg_gap,
             cfg_count, cfg_rearm,
      output pulse_out, armed, busy, done, pulse_index
   );
endinterface

// File: rtl/pulse_train_scheduler.sv
// ----------------------------------------------------------------------------
// pulse_train_scheduler
// Once armed, waits for a rising edge on trigger_in. It then waits cfg_delay
// cycles and emits cfg_count pulses, each cfg_width cycles high, separated by
// cfg_gap low cycles. A width or gap of 0 is treated as 1.
// Ports:
//   sampleclk : sole clock, rising edge
//   reset     : synchronous, active-high
//   bus       : pulse_train_scheduler_if.slave
//               inputs  arm, abort, trigger_in, cfg_delay/width/gap/count,
//                       cfg_rearm
//               outputs pulse_out, armed, busy, done, pulse_index
// ----------------------------------------------------------------------------
module pulse_train_scheduler #(
   parameter int CNT_W = 16,
   parameter int NUM_W = 8
) (
   input  logic                    sampleclk,
   input  logic                    reset,
   pulse_train_scheduler_if.slave  bus
);
   typedef enum logic [2:0] {
      S_IDLE, S_ARMED, S_DELAY, S_PULSE, S_GAP, S_DONE
   } state_t;

   state_t           state_q;
   logic             trig_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] delay_q;
   logic [CNT_W-1:0] width_q;   // already clamped to >= 1
   logic [CNT_W-1:0] gap_q;     // already clamped to >= 1
   logic [NUM_W-1:0] count_q;
   logic             pulse_q;
   logic             done_q;
   logic [NUM_W-1:0] index_q;

   logic             edge_d;
   logic [CNT_W-1:0] width_d;
   logic [CNT_W-1:0] gap_d;

   assign edge_d  = bus.trigger_in & ~trig_q;
   assign width_d = (bus.cfg_width == '0) ? CNT_W'(1) : bus.cfg_width;
   assign gap_d   = (bus.cfg_gap   == '0) ? CNT_W'(1) : bus.cfg_gap;

   // The counter runs 1..limit and is compared for equality, so a limit of
   // 2^CNT_W-1 never wraps.
   always_ff @(posedge sampleclk) begin
      if (reset) begin
         state_q <= S_IDLE;
         trig_q  <= 1'b0;
         cnt_q   <= '0;
         delay_q <= '0;
         width_q <= '0;
         gap_q   <= '0;
         count_q <= '0;
         pulse_q <= 1'b0;
         done_q  <= 1'b0;
         index_q <= '0;
      end else begin
         trig_q <= bus.trigger_in;
         done_q <= 1'b0;
         if (bus.abort) begin
            // pulse_index is kept so the aborted position can be inspected
            state_q <= S_IDLE;
            pulse_q <= 1'b0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  // an edge in the arming cycle is deliberately not used
                  if (bus.arm) begin
                     state_q <= S_ARMED;
                     index_q <= '0;
                  end
               end
               S_ARMED: begin
                  if (edge_d) begin
                     delay_q <= bus.cfg_delay;
                     width_q <= width_d;
                     gap_q   <= gap_d;
                     count_q <= bus.cfg_count;
                     cnt_q   <= CNT_W'(1);
                     if (bus.cfg_count == '0) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                     end else if (bus.cfg_delay == '0) begin
                        state_q <= S_PULSE;
                        pulse_q <= 1'b1;
                        index_q <= index_q + NUM_W'(1);
                     end else begin
                        state_q <= S_DELAY;
                     end
                  end
               end
               S_DELAY: begin
                  if (cnt_q == delay_q) begin
                     state_q <= S_PULSE;
                     pulse_q <= 1'b1;
                     cnt_q   <= CNT_W'(1);
                     index_q <= index_q + NUM_W'(1);
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
               S_PULSE: begin
                  if (cnt_q == width_q) begin
                     pulse_q <= 1'b0;
                     cnt_q   <= CNT_W'(1);
                     if (index_q == count_q) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                     end else begin
                        state_q <= S_GAP;
                     end
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
               S_GAP: begin
                  if (cnt_q == gap_q) begin
                     state_q <= S_PULSE;
                     pulse_q <= 1'b1;
                     cnt_q   <= CNT_W'(1);
                     index_q <= index_q + NUM_W'(1);
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
               S_DONE: begin
                  if (bus.cfg_rearm) begin
                     state_q <= S_ARMED;
                     index_q <= '0;
                  end else begin
                     state_q <= S_IDLE;
                  end
               end
               default: begin
                  state_q <= S_IDLE;
                  pulse_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.pulse_out   = pulse_q;
   assign bus.done        = done_q;
   assign bus.pulse_index = index_q;
   assign bus.armed       = (state_q == S_ARMED);
   assign bus.busy        = (state_q == S_DELAY) || (state_q == S_PULSE) ||
                            (state_q == S_GAP);
endmodule

// File: tb/tb_pulse_train_scheduler.sv
// ----------------------------------------------------------------------------
// tb_pulse_train_scheduler
// Directed scenarios for pulse_train_scheduler. Inputs are driven 1 time unit
// after a rising edge and outputs are observed at the same point. The k-th
// observation after the trigger edge is raised shows the value the outputs
// hold in cycle E0+k.
// ----------------------------------------------------------------------------
module tb_pulse_train_scheduler;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   pulse_train_scheduler_if #(.CNT_W(16), .NUM_W(8)) bus ();

   pulse_train_scheduler #(.CNT_W(16), .NUM_W(8)) dut (
      .sampleclk (clk),
      .reset     (rst),
      .bus       (bus)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_cfg(input int d, input int w, input int g, input int c, input logic r);
      bus.cfg_delay = 16'(d);
      bus.cfg_width = 16'(w);
      bus.cfg_gap   = 16'(g);
      bus.cfg_count = 8'(c);
      bus.cfg_rearm = r;
   endtask

   task automatic do_arm();
      bus.arm = 1'b1;
      tick();
      bus.arm = 1'b0;
   endtask

   task automatic test_reset();
      logic seen;
      bus.arm = 0; bus.abort = 0; bus.trigger_in = 0;
      set_cfg(0, 10, 1, 1, 1'b0);
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      checks++;
      if ({bus.pulse_out, bus.armed, bus.busy, bus.done, bus.pulse_index} !== 12'h0) begin
         errors++;
         $display("FAIL reset_state: got %b required 0",
                  {bus.pulse_out, bus.armed, bus.busy, bus.done, bus.pulse_index});
      end
      do_arm();
      bus.trigger_in = 1'b1;
      tick(); tick(); tick();
      checks++;
      if (bus.pulse_out !== 1'b1) begin
         errors++; $display("FAIL reset_pre_pulse: pulse_out=%b required 1", bus.pulse_out);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if ({bus.pulse_out, bus.armed, bus.busy, bus.done, bus.pulse_index} !== 12'h0) begin
         errors++;
         $display("FAIL reset_mid_pulse: got %b required 0",
                  {bus.pulse_out, bus.armed, bus.busy, bus.done, bus.pulse_index});
      end
      bus.trigger_in = 1'b0;
      tick();
      bus.trigger_in = 1'b1;
      seen = 1'b0;
      for (int k = 1; k <= 15; k++) begin
         tick();
         if (bus.pulse_out || bus.busy || bus.armed) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++; $display("FAIL reset_no_arm: activity=%b required 0", seen);
      end
      bus.trigger_in = 1'b0;
      $display("test_reset: done");
   endtask

   task automatic test_basic();
      logic exp_p, exp_d;
      set_cfg(5, 3, 2, 3, 1'b0);
      do_arm();
      checks++;
      if (bus.armed !== 1'b1) begin
         errors++; $display("FAIL basic_armed: armed=%b required 1", bus.armed);
      end
      bus.trigger_in = 1'b1;
      for (int k = 1; k <= 21; k++) begin
         tick();
         exp_p = (k >= 6 && k <= 8) || (k >= 11 && k <= 13) || (k >= 16 && k <= 18);
         exp_d = (k == 19);
         checks++;
         if (bus.pulse_out !== exp_p) begin
            errors++; $display("FAIL basic_pulse cycle E0+%0d: pulse_out=%b required %b", k, bus.pulse_out, exp_p);
         end
         checks++;
         if (bus.done !== exp_d) begin
            errors++; $display("FAIL basic_done cycle E0+%0d: done=%b required %b", k, bus.done, exp_d);
         end
         if (k == 3) begin
            checks++;
            if (bus.busy !== 1'b1) begin
               errors++; $display("FAIL basic_busy: busy=%b required 1", bus.busy);
            end
         end
      end
      checks++;
      if (bus.pulse_index !== 8'd3) begin
         errors++; $display("FAIL basic_index: pulse_index=%0d required 3", bus.pulse_index);
      end
      checks++;
      if ({bus.armed, bus.busy} !== 2'b00) begin
         errors++; $display("FAIL basic_idle: armed,busy=%b required 00", {bus.armed, bus.busy});
      end
      bus.trigger_in = 1'b0;
      tick();
      $display("test_basic: done");
   endtask

   task automatic test_zero_params();
      logic exp_p, exp_d;
      set_cfg(0, 0, 0, 2, 1'b0);
      do_arm();
      bus.trigger_in = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         tick();
         exp_p = (k == 1) || (k == 3);
         exp_d = (k == 4);
         checks++;
         if (bus.pulse_out !== exp_p) begin
            errors++; $display("FAIL zero_pulse cycle E0+%0d: pulse_out=%b required %b", k, bus.pulse_out, exp_p);
         end
         checks++;
         if (bus.done !== exp_d) begin
            errors++; $display("FAIL zero_done cycle E0+%0d: done=%b required %b", k, bus.done, exp_d);
         end
      end
      checks++;
      if (bus.pulse_index !== 8'd2) begin
         errors++; $display("FAIL zero_index: pulse_index=%0d required 2", bus.pulse_index);
      end
      bus.trigger_in = 1'b0;
      tick();
      $display("test_zero_params: done");
   endtask

   task automatic test_count_zero();
      set_cfg(3, 2, 2, 0, 1'b1);
      do_arm();
      bus.trigger_in = 1'b1;
      tick();
      checks++;
      if ({bus.done, bus.pulse_out, bus.busy} !== 3'b100) begin
         errors++; $display("FAIL cnt0_done: done,pulse,busy=%b required 100", {bus.done, bus.pulse_out, bus.busy});
      end
      tick();
      checks++;
      if ({bus.armed, bus.done} !== 2'b10) begin
         errors++; $display("FAIL cnt0_rearm: armed,done=%b required 10", {bus.armed, bus.done});
      end
      set_cfg(0, 1, 1, 1, 1'b1);
      bus.trigger_in = 1'b0;
      tick();
      bus.trigger_in = 1'b1;
      tick();
      checks++;
      if (bus.pulse_out !== 1'b1) begin
         errors++; $display("FAIL cnt0_second_edge: pulse_out=%b required 1", bus.pulse_out);
      end
      tick();
      checks++;
      if ({bus.done, bus.pulse_out, bus.pulse_index} !== {1'b1, 1'b0, 8'd1}) begin
         errors++; $display("FAIL cnt0_second_done: done=%b pulse=%b index=%0d required 1 0 1",
                            bus.done, bus.pulse_out, bus.pulse_index);
      end
      tick();
      checks++;
      if ({bus.armed, bus.pulse_index} !== {1'b1, 8'd0}) begin
         errors++; $display("FAIL cnt0_rearm_clear: armed=%b index=%0d required 1 0", bus.armed, bus.pulse_index);
      end
      bus.cfg_rearm = 1'b0;
      bus.trigger_in = 1'b0;
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      checks++;
      if (bus.armed !== 1'b0) begin
         errors++; $display("FAIL cnt0_abort_armed: armed=%b required 0", bus.armed);
      end
      $display("test_count_zero: done");
   endtask

   task automatic test_cfg_shadow();
      logic exp_p, exp_d;
      set_cfg(4, 3, 1, 2, 1'b0);
      do_arm();
      bus.trigger_in = 1'b1;
      for (int k = 1; k <= 13; k++) begin
         tick();
         if (k == 2) bus.cfg_width = 16'd10;
         exp_p = (k >= 5 && k <= 7) || (k >= 9 && k <= 11);
         exp_d = (k == 12);
         checks++;
         if (bus.pulse_out !== exp_p) begin
            errors++; $display("FAIL shadow_pulse cycle E0+%0d: pulse_out=%b required %b", k, bus.pulse_out, exp_p);
         end
         checks++;
         if (bus.done !== exp_d) begin
            errors++; $display("FAIL shadow_done cycle E0+%0d: done=%b required %b", k, bus.done, exp_d);
         end
      end
      bus.trigger_in = 1'b0;
      tick();
      $display("test_cfg_shadow: done");
   endtask

   task automatic test_abort();
      logic seen;
      set_cfg(2, 2, 3, 4, 1'b0);
      do_arm();
      bus.trigger_in = 1'b1;
      // pulse 1 at E0+3..4, gap E0+5..7, pulse 2 at E0+8..9, gap E0+10..12
      for (int k = 1; k <= 10; k++) tick();
      checks++;
      if ({bus.pulse_out, bus.busy, bus.pulse_index} !== {1'b0, 1'b1, 8'd2}) begin
         errors++; $display("FAIL abort_in_gap: pulse=%b busy=%b index=%0d required 0 1 2",
                            bus.pulse_out, bus.busy, bus.pulse_index);
      end
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      checks++;
      if ({bus.pulse_out, bus.busy, bus.armed, bus.done, bus.pulse_index} !== {4'b0000, 8'd2}) begin
         errors++; $display("FAIL abort_idle: pulse,busy,armed,done=%b index=%0d required 0000 2",
                            {bus.pulse_out, bus.busy, bus.armed, bus.done}, bus.pulse_index);
      end
      seen = 1'b0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (bus.pulse_out || bus.done || bus.busy) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++; $display("FAIL abort_quiet: activity=%b required 0", seen);
      end
      // trigger still held high through arming: must not fire
      do_arm();
      seen = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         if (bus.busy || bus.pulse_out) seen = 1'b1;
      end
      checks++;
      if ({seen, bus.armed, bus.pulse_index} !== {1'b0, 1'b1, 8'd0}) begin
         errors++; $display("FAIL held_trigger: activity=%b armed=%b index=%0d required 0 1 0",
                            seen, bus.armed, bus.pulse_index);
      end
      bus.trigger_in = 1'b0;
      tick();
      bus.trigger_in = 1'b1;
      tick();
      checks++;
      if ({bus.busy, bus.armed} !== 2'b10) begin
         errors++; $display("FAIL retoggle_fire: busy,armed=%b required 10", {bus.busy, bus.armed});
      end
      bus.abort = 1'b1;
      bus.arm   = 1'b1;
      tick();
      bus.abort = 1'b0;
      bus.arm   = 1'b0;
      bus.trigger_in = 1'b0;
      checks++;
      if ({bus.armed, bus.busy} !== 2'b00) begin
         errors++; $display("FAIL abort_beats_arm: armed,busy=%b required 00", {bus.armed, bus.busy});
      end
      // arm and an edge in the same IDLE cycle: the edge is dropped
      tick();
      bus.arm = 1'b1;
      bus.trigger_in = 1'b1;
      tick();
      bus.arm = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         if (bus.busy || bus.pulse_out || !bus.armed) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++; $display("FAIL arm_edge_same_cycle: activity=%b required 0", seen);
      end
      bus.trigger_in = 1'b0;
      $display("test_abort: done");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero_params();
      test_count_zero();
      test_cfg_shadow();
      test_abort();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
